cdb_arbiter: RTL

Shares the two common-data-bus broadcast lanes (CDB lane 1 and lane 2) among the functional units: adder, load, store-address and branch units. Each unit offers one completed result (ROB index plus 32-bit value) through a valid/ready handshake. The arbiter grants up to two requesters per cycle in round-robin order and drives registered broadcast pulses that the reorder buffer and reservation stations capture on the rising edge of CDBisCast1/2. It also enforces the pulse-gap rule those edge-triggered consumers need, and drops all in-flight work on a pipeline flush.

---
 rtl/cdb_pkg.sv | 29 ++
 rtl/cdb_arbiter_if.sv | 31 +++
 rtl/rr_pick2.sv | 57 +++++
 rtl/cdb_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
// Lane payload struct and requester index map.
package cdb_pkg;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 32;
    localparam int ROB_IDX_W = 6;
    localparam int ROB_DEPTH = 16;
    localparam int REQ_IDX_W = $clog2(NUM_REQ);
    localparam int NUM_LANE  = 2;

    localparam logic [ROB_IDX_W-1:0] INVALID_ROB = 6'b010000;

    localparam int REQ_ADDER = 0;
    localparam int REQ_LOAD  = 1;
    localparam int REQ_STORE = 2;
    localparam int REQ_BNE   = 3;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] robNum;
        logic [DATA_W-1:0]    data;
    } cdb_lane_t;

    function automatic logic is_bad_tag(input logic [ROB_IDX_W-1:0] rob);
        return rob >= ROB_IDX_W'(ROB_DEPTH);
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit offer handshake plus the two CDB broadcast lanes.
// master = functional-unit side, slave = arbiter side.
interface cdb_arbiter_if;
    import cdb_pkg::*;

    logic                           cataclysm;
    logic [NUM_REQ-1:0]             reqValid;
    logic [NUM_REQ*ROB_IDX_W-1:0]   reqRobNum;
    logic [NUM_REQ*DATA_W-1:0]      reqData;
    logic [NUM_REQ-1:0]             reqReady;
    logic                           CDBisCast1;
    logic [ROB_IDX_W-1:0]           CDBrobNum1;
    logic [DATA_W-1:0]              CDBdata1;
    logic                           CDBisCast2;
    logic [ROB_IDX_W-1:0]           CDBrobNum2;
    logic [DATA_W-1:0]              CDBdata2;
    logic [REQ_IDX_W-1:0]           rrPtr;

    modport master (
        output cataclysm, reqValid, reqRobNum, reqData,
        input  reqReady, CDBisCast1, CDBrobNum1, CDBdata1,
        input  CDBisCast2, CDBrobNum2, CDBdata2, rrPtr
    );

    modport slave (
        input  cataclysm, reqValid, reqRobNum, reqData,
        output reqReady, CDBisCast1, CDBrobNum1, CDBdata1,
        output CDBisCast2, CDBrobNum2, CDBdata2, rrPtr
    );

endinterface

// File: rtl/rr_pick2.sv
// Round-robin picker: up to two grants per cycle onto free lanes.
// Bad-tag offers are granted without occupying a lane.
module rr_pick2
    import cdb_pkg::*;
(
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   bad,
    input  logic [REQ_IDX_W-1:0] ptr,
    input  logic [NUM_LANE-1:0]  free,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   sel1,
    output logic [NUM_REQ-1:0]   sel2,
    output logic                 any,
    output logic [REQ_IDX_W-1:0] nxt_ptr
);

    logic [1:0]           cap;
    logic [1:0]           ngnt;
    logic                 taken1;
    logic                 taken2;
    logic [REQ_IDX_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        sel1    = '0;
        sel2    = '0;
        any     = 1'b0;
        nxt_ptr = ptr;
        ngnt    = 2'd0;
        idx     = ptr;
        taken1  = ~free[0];
        taken2  = ~free[1];
        cap     = {1'b0, free[0]} + {1'b0, free[1]};
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + REQ_IDX_W'(k);
            if (req[idx] && (ngnt < cap)) begin
                if (bad[idx]) begin
                    gnt[idx] = 1'b1;
                end else if (!taken1) begin
                    gnt[idx]  = 1'b1;
                    sel1[idx] = 1'b1;
                    taken1    = 1'b1;
                end else if (!taken2) begin
                    gnt[idx]  = 1'b1;
                    sel2[idx] = 1'b1;
                    taken2    = 1'b1;
                end
                if (gnt[idx]) begin
                    ngnt    = ngnt + 2'd1;
                    any     = 1'b1;
                    nxt_ptr = idx + REQ_IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-lane CDB arbiter: registered one-cycle broadcast pulses with a
// mandatory low cycle between pulses, round-robin fairness and flush.
module cdb_arbiter
    import cdb_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cataclysm,
    input  logic [NUM_REQ-1:0]           reqValid,
    input  logic [NUM_REQ*ROB_IDX_W-1:0] reqRobNum,
    input  logic [NUM_REQ*DATA_W-1:0]    reqData,
    output logic [NUM_REQ-1:0]           reqReady,
    output logic                         CDBisCast1,
    output logic [ROB_IDX_W-1:0]         CDBrobNum1,
    output logic [DATA_W-1:0]            CDBdata1,
    output logic                         CDBisCast2,
    output logic [ROB_IDX_W-1:0]         CDBrobNum2,
    output logic [DATA_W-1:0]            CDBdata2,
    output logic [REQ_IDX_W-1:0]         rrPtr
);

    cdb_lane_t            lane1_q, lane1_d;
    cdb_lane_t            lane2_q, lane2_d;
    logic [REQ_IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [ROB_IDX_W-1:0] rob [NUM_REQ];
    logic [DATA_W-1:0]    dat [NUM_REQ];
    logic [NUM_REQ-1:0]   bad;
    logic [NUM_REQ-1:0]   gnt, sel1, sel2;
    logic                 any;
    logic [REQ_IDX_W-1:0] nxt_ptr;
    logic [NUM_LANE-1:0]  free;

    always_comb begin
        bad = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rob[i] = reqRobNum[i*ROB_IDX_W +: ROB_IDX_W];
            dat[i] = reqData[i*DATA_W +: DATA_W];
            bad[i] = is_bad_tag(rob[i]);
        end
    end

    // A lane that pulsed last cycle must sit low now so the next pulse
    // is seen as a fresh rising edge by the consumers.
    assign free = {~lane2_q.valid, ~lane1_q.valid};

    rr_pick2 u_pick (
        .req     (reqValid),
        .bad     (bad),
        .ptr     (rr_ptr_q),
        .free    (free),
        .gnt     (gnt),
        .sel1    (sel1),
        .sel2    (sel2),
        .any     (any),
        .nxt_ptr (nxt_ptr)
    );

    assign reqReady = (rst_n && !cataclysm) ? gnt : '0;

    always_comb begin
        lane1_d       = lane1_q;
        lane2_d       = lane2_q;
        lane1_d.valid = 1'b0;
        lane2_d.valid = 1'b0;
        rr_ptr_d      = rr_ptr_q;
        if (!cataclysm) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (sel1[i]) lane1_d = '{1'b1, rob[i], dat[i]};
                if (sel2[i]) lane2_d = '{1'b1, rob[i], dat[i]};
            end
            if (any) rr_ptr_d = nxt_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane1_q  <= '{1'b0, INVALID_ROB, '0};
            lane2_q  <= '{1'b0, INVALID_ROB, '0};
            rr_ptr_q <= '0;
        end else begin
            lane1_q  <= lane1_d;
            lane2_q  <= lane2_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign CDBisCast1 = lane1_q.valid;
    assign CDBrobNum1 = lane1_q.robNum;
    assign CDBdata1   = lane1_q.data;
    assign CDBisCast2 = lane2_q.valid;
    assign CDBrobNum2 = lane2_q.robNum;
    assign CDBdata2   = lane2_q.data;
    assign rrPtr      = rr_ptr_q;

endmodule
